// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline control unit for a classic five-stage core. It decides, cycle by
// cycle, which pipeline registers load (WEN) and which are turned into bubbles
// (flush). It also decides whether the PC advances.
//
// Hazards handled, highest priority first:
//   halt in WB, D-memory wait, branch/jump redirect, load-use, I-cache miss.
//
// It also keeps two saturating performance counters and a sticky error flag
// for a D-memory access that never completes.
//
// Parameters
//   CNT_W        width of stall_cycles / flush_events (both saturate)
//   MEM_TIMEOUT  consecutive D-memory wait cycles that raise mem_timeout
//
// Ports
//   CLK, RST                      clock; synchronous active-high reset
//   ifid_rs, ifid_rt, ifid_uses_rt  source registers of the instruction in ID
//   idex_dREN, idex_rt            load in EX and its destination register
//   exmem_redirect                taken branch/jump resolved in MEM
//   exmem_dmem_req, dhit          D-memory request in MEM and its completion
//   ihit                          instruction fetch valid this cycle
//   memwb_halt                    halt instruction has reached WB
//   pc_WEN                        PC update enable
//   <stage>_WEN / <stage>_flush   load enable / bubble insert per pipe register
//   halted                        core stopped (sticky until RST)
//   mem_timeout                   D-memory wait exceeded MEM_TIMEOUT (sticky)
//   stall_cycles                  cycles the PC was held while running
//   flush_events                  number of redirect cycles
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             ifid_uses_rt,
    input  logic             idex_dREN,
    input  logic [4:0]       idex_rt,
    input  logic             exmem_redirect,
    input  logic             exmem_dmem_req,
    input  logic             dhit,
    input  logic             ihit,
    input  logic             memwb_halt,
    output logic             pc_WEN,
    output logic             ifid_WEN,
    output logic             ifid_flush,
    output logic             idex_WEN,
    output logic             idex_flush,
    output logic             exmem_WEN,
    output logic             exmem_flush,
    output logic             memwb_WEN,
    output logic             memwb_flush,
    output logic             halted,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    // The wait counter must be able to hold MEM_TIMEOUT itself so that the
    // threshold compare can see the exact cycle the limit is reached.
    localparam int                 WAIT_W     = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0]  WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        HALT    = 2'd2
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_cnt_next;
    logic              load_use;
    logic              dmem_wait;
    logic              count_stall;
    logic              count_flush;
    logic              set_timeout;

    // Hazard detection. Register 0 is hardwired to zero, so a load into it
    // never creates a real dependency.
    always_comb begin
        load_use  = idex_dREN && (idex_rt != 5'd0) &&
                    ((idex_rt == ifid_rs) ||
                     (ifid_uses_rt && (idex_rt == ifid_rt)));
        dmem_wait = exmem_dmem_req && !dhit;
    end

    // Next-state and pipeline control. Every branch that raises a flush also
    // drops the matching WEN, so a bubble can never be overwritten by a load.
    always_comb begin
        pc_WEN        = 1'b1;
        ifid_WEN      = 1'b1;
        ifid_flush    = 1'b0;
        idex_WEN      = 1'b1;
        idex_flush    = 1'b0;
        exmem_WEN     = 1'b1;
        exmem_flush   = 1'b0;
        memwb_WEN     = 1'b1;
        memwb_flush   = 1'b0;
        next_state    = state;
        wait_cnt_next = wait_cnt;
        count_stall   = 1'b0;
        count_flush   = 1'b0;
        set_timeout   = 1'b0;

        if (RST) begin
            pc_WEN    = 1'b0;
            ifid_WEN  = 1'b0;
            idex_WEN  = 1'b0;
            exmem_WEN = 1'b0;
            memwb_WEN = 1'b0;
        end else begin
            case (state)
                RUN, MEMWAIT: begin
                    if (memwb_halt) begin
                        // Freeze everything; the halt instruction stays in WB.
                        pc_WEN     = 1'b0;
                        ifid_WEN   = 1'b0;
                        idex_WEN   = 1'b0;
                        exmem_WEN  = 1'b0;
                        memwb_WEN  = 1'b0;
                        next_state = HALT;
                    end else if (dmem_wait) begin
                        // Hold the front of the pipe and the MEM instruction;
                        // WB receives a bubble until memory answers.
                        pc_WEN      = 1'b0;
                        ifid_WEN    = 1'b0;
                        idex_WEN    = 1'b0;
                        exmem_WEN   = 1'b0;
                        memwb_WEN   = 1'b0;
                        memwb_flush = 1'b1;
                        next_state  = MEMWAIT;
                        if (wait_cnt != {WAIT_W{1'b1}}) begin
                            wait_cnt_next = wait_cnt + 1'b1;
                        end
                        set_timeout = (wait_cnt_next >= WAIT_LIMIT);
                    end else begin
                        // Memory is idle or just answered: normal hazard
                        // resolution applies in this same cycle.
                        next_state    = RUN;
                        wait_cnt_next = '0;
                        if (exmem_redirect) begin
                            // Everything younger than the branch is on the
                            // wrong path; the PC takes the target.
                            ifid_WEN    = 1'b0;
                            ifid_flush  = 1'b1;
                            idex_WEN    = 1'b0;
                            idex_flush  = 1'b1;
                            exmem_WEN   = 1'b0;
                            exmem_flush = 1'b1;
                            count_flush = 1'b1;
                        end else if (load_use) begin
                            // Hold the consumer in ID one cycle and send a
                            // bubble into EX behind the load.
                            pc_WEN     = 1'b0;
                            ifid_WEN   = 1'b0;
                            idex_WEN   = 1'b0;
                            idex_flush = 1'b1;
                        end else if (!ihit) begin
                            // No valid fetch: keep the PC and feed a bubble.
                            pc_WEN     = 1'b0;
                            ifid_WEN   = 1'b0;
                            ifid_flush = 1'b1;
                        end
                    end
                    count_stall = !pc_WEN;
                end
                HALT: begin
                    pc_WEN    = 1'b0;
                    ifid_WEN  = 1'b0;
                    idex_WEN  = 1'b0;
                    exmem_WEN = 1'b0;
                    memwb_WEN = 1'b0;
                end
                default: begin
                    // Unreachable encoding: stop the pipe and recover to RUN.
                    pc_WEN     = 1'b0;
                    ifid_WEN   = 1'b0;
                    idex_WEN   = 1'b0;
                    exmem_WEN  = 1'b0;
                    memwb_WEN  = 1'b0;
                    next_state = RUN;
                end
            endcase
        end
    end

    // State, wait counter, sticky flags and saturating performance counters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= RUN;
            wait_cnt     <= '0;
            halted       <= 1'b0;
            mem_timeout  <= 1'b0;
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            state    <= next_state;
            wait_cnt <= wait_cnt_next;
            if (next_state == HALT) begin
                halted <= 1'b1;
            end
            if (set_timeout) begin
                mem_timeout <= 1'b1;
            end
            if (count_stall && (stall_cycles != {CNT_W{1'b1}})) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            if (count_flush && (flush_events != {CNT_W{1'b1}})) begin
                flush_events <= flush_events + 1'b1;
            end
        end
    end

endmodule
